// File: rtl/rect_fill_engine_if.sv
// Command handshake and frame-buffer write port of the rectangle fill engine.
// The slave side is the engine; the master side issues commands and watches writes.
interface rect_fill_engine_if #(
  parameter int COLOR_W = 12
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [8:0]         cmd_x0;
  logic [8:0]         cmd_y0;
  logic [8:0]         cmd_x1;
  logic [8:0]         cmd_y1;
  logic [COLOR_W-1:0] cmd_color;
  logic               cmd_clear;
  logic               cmd_sync;
  logic [8:0]         i;
  logic [8:0]         j;
  logic [COLOR_W-1:0] wval;
  logic               rw;

  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, cmd_clear, cmd_sync,
    input  cmd_ready, i, j, wval, rw
  );

  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, cmd_clear, cmd_sync,
    output cmd_ready, i, j, wval, rw
  );
endinterface

// File: rtl/rect_fill_engine.sv
// Rectangle / full-frame fill engine: accepts one command at a time and streams
// one pixel write per clock in raster order, optionally starting on vsync.
module rect_fill_engine #(
  parameter int FB_W    = 320,
  parameter int FB_H    = 240,
  parameter int COLOR_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  rect_fill_engine_if.slave   bus,
  input  logic                vsync_pulse,
  input  logic                abort,
  output logic                busy,
  output logic                done
);

  localparam logic [8:0] X_MAX = 9'(FB_W - 1);
  localparam logic [8:0] Y_MAX = 9'(FB_H - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SYNC,
    FILL,
    DONE
  } state_t;

  state_t state_reg, state_next;

  // Axis 0 is x (columns), axis 1 is y (rows); both normalise identically.
  logic [1:0][8:0] raw_a;
  logic [1:0][8:0] raw_b;
  logic [1:0][8:0] lim;
  logic [1:0][8:0] norm_lo;
  logic [1:0][8:0] norm_hi;

  assign raw_a[0] = bus.cmd_x0;
  assign raw_b[0] = bus.cmd_x1;
  assign raw_a[1] = bus.cmd_y0;
  assign raw_b[1] = bus.cmd_y1;
  assign lim[0]   = X_MAX;
  assign lim[1]   = Y_MAX;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      logic [8:0] clamp_a;
      logic [8:0] clamp_b;
      assign clamp_a     = (raw_a[gi] > lim[gi]) ? lim[gi] : raw_a[gi];
      assign clamp_b     = (raw_b[gi] > lim[gi]) ? lim[gi] : raw_b[gi];
      assign norm_lo[gi] = bus.cmd_clear ? 9'd0 :
                           ((clamp_a > clamp_b) ? clamp_b : clamp_a);
      assign norm_hi[gi] = bus.cmd_clear ? lim[gi] :
                           ((clamp_a > clamp_b) ? clamp_a : clamp_b);
    end
  endgenerate

  logic [8:0]         x0_reg, x0_next;
  logic [8:0]         x1_reg, x1_next;
  logic [8:0]         y1_reg, y1_next;
  logic [8:0]         i_reg, i_next;
  logic [8:0]         j_reg, j_next;
  logic [COLOR_W-1:0] wval_reg, wval_next;
  logic               rw_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               ready_reg;
  logic               accept;
  logic               last_pixel;

  assign accept     = bus.cmd_valid && ready_reg;
  assign last_pixel = (i_reg == y1_reg) && (j_reg == x1_reg);

  always_comb begin
    state_next = state_reg;
    x0_next    = x0_reg;
    x1_next    = x1_reg;
    y1_next    = y1_reg;
    i_next     = i_reg;
    j_next     = j_reg;
    wval_next  = wval_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          x0_next    = norm_lo[0];
          x1_next    = norm_hi[0];
          y1_next    = norm_hi[1];
          i_next     = norm_lo[1];
          j_next     = norm_lo[0];
          wval_next  = bus.cmd_color;
          state_next = bus.cmd_sync ? WAIT_SYNC : FILL;
        end
      end
      WAIT_SYNC: begin
        if (abort) begin
          state_next = DONE;
        end else if (vsync_pulse) begin
          state_next = FILL;
        end
      end
      FILL: begin
        // i/j hold the pixel being written this cycle; advance only if more remain.
        if (abort || last_pixel) begin
          state_next = DONE;
        end else if (j_reg == x1_reg) begin
          j_next = x0_reg;
          i_next = i_reg + 9'd1;
        end else begin
          j_next = j_reg + 9'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Every output is derived from the next state so it is registered and holds
  // for the whole cycle in which that state is current.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      x0_reg    <= '0;
      x1_reg    <= '0;
      y1_reg    <= '0;
      i_reg     <= '0;
      j_reg     <= '0;
      wval_reg  <= '0;
      rw_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      x0_reg    <= x0_next;
      x1_reg    <= x1_next;
      y1_reg    <= y1_next;
      i_reg     <= i_next;
      j_reg     <= j_next;
      wval_reg  <= wval_next;
      rw_reg    <= (state_next == FILL);
      busy_reg  <= (state_next == FILL) || (state_next == WAIT_SYNC);
      done_reg  <= (state_next == DONE);
      ready_reg <= (state_next == IDLE);
    end
  end

  assign bus.cmd_ready = ready_reg;
  assign bus.i         = i_reg;
  assign bus.j         = j_reg;
  assign bus.wval      = wval_reg;
  assign bus.rw        = rw_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Bench for rect_fill_engine: a rectangle-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_rect_fill_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vsync_pulse = 1'b0;
  logic abort = 1'b0;
  logic busy;
  logic done;

  rect_fill_engine_if #(.COLOR_W(12)) bus ();

  rect_fill_engine #(.FB_W(320), .FB_H(240), .COLOR_W(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .vsync_pulse (vsync_pulse),
    .abort       (abort),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int fail_prints = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (fail_prints < 40)
        $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      fail_prints++;
    end
  endtask

  function automatic int clampi(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic int mini(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int absi(input int a);
    return (a < 0) ? -a : a;
  endfunction

  // Reference model: a command is a rectangle origin, width and pixel total;
  // the k-th write lands at (y0 + k / w, x0 + k % w).
  // Modes: 0 idle, 1 waiting for vsync, 2 writing, 3 completion cycle.
  int m_mode = 0;
  int m_count = 0;
  int r_x0 = 0;
  int r_y0 = 0;
  int r_w = 1;
  int r_total = 1;
  int m_ready = 0;
  int m_rw = 0;
  int m_busy = 0;
  int m_done = 0;
  int m_wval = 0;

  always @(posedge clk or posedge rst) begin
    int xa, xb, ya, yb;
    if (rst) begin
      m_mode  <= 0;
      m_ready <= 0;
      m_rw    <= 0;
      m_busy  <= 0;
      m_done  <= 0;
      m_count <= 0;
    end else begin
      case (m_mode)
        0: begin
          if (m_ready == 1 && bus.cmd_valid) begin
            xa = bus.cmd_clear ? 0   : clampi(int'(bus.cmd_x0), 319);
            xb = bus.cmd_clear ? 319 : clampi(int'(bus.cmd_x1), 319);
            ya = bus.cmd_clear ? 0   : clampi(int'(bus.cmd_y0), 239);
            yb = bus.cmd_clear ? 239 : clampi(int'(bus.cmd_y1), 239);
            r_x0    <= mini(xa, xb);
            r_y0    <= mini(ya, yb);
            r_w     <= absi(xa - xb) + 1;
            r_total <= (absi(xa - xb) + 1) * (absi(ya - yb) + 1);
            m_count <= 0;
            m_wval  <= int'(bus.cmd_color);
            m_ready <= 0;
            m_busy  <= 1;
            if (bus.cmd_sync) begin
              m_mode <= 1;
            end else begin
              m_mode <= 2;
              m_rw   <= 1;
            end
          end else begin
            m_ready <= 1;
          end
        end
        1: begin
          if (abort) begin
            m_mode <= 3;
            m_busy <= 0;
            m_done <= 1;
          end else if (vsync_pulse) begin
            m_mode <= 2;
            m_rw   <= 1;
          end
        end
        2: begin
          m_count <= m_count + 1;
          if (abort || (m_count + 1 == r_total)) begin
            m_mode <= 3;
            m_rw   <= 0;
            m_busy <= 0;
            m_done <= 1;
          end
        end
        default: begin
          m_mode  <= 0;
          m_done  <= 0;
          m_ready <= 1;
        end
      endcase
    end
  end

  // Per-cycle comparison and write capture, on the inactive edge.
  int wr_count = 0;
  int done_count = 0;
  int first_i = -1;
  int first_j = -1;
  int first_wval = -1;
  int last_i = -1;
  int last_j = -1;
  int qi[$];
  int qj[$];

  always @(negedge clk) begin
    chk("cmd_ready", int'(bus.cmd_ready), m_ready);
    chk("rw", int'(bus.rw), m_rw);
    chk("busy", int'(busy), m_busy);
    chk("done", int'(done), m_done);
    if (m_rw == 1) begin
      chk("row", int'(bus.i), r_y0 + m_count / r_w);
      chk("col", int'(bus.j), r_x0 + m_count % r_w);
      chk("wval", int'(bus.wval), m_wval);
    end
    if (bus.rw) begin
      if (wr_count == 0) begin
        first_i    = int'(bus.i);
        first_j    = int'(bus.j);
        first_wval = int'(bus.wval);
      end
      last_i = int'(bus.i);
      last_j = int'(bus.j);
      if (qi.size() < 8) begin
        qi.push_back(int'(bus.i));
        qj.push_back(int'(bus.j));
      end
      wr_count++;
    end
    if (done) done_count++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_capture();
    wr_count   = 0;
    done_count = 0;
    first_i    = -1;
    first_j    = -1;
    first_wval = -1;
    last_i     = -1;
    last_j     = -1;
    qi.delete();
    qj.delete();
  endtask

  task automatic send(input int x0, input int y0, input int x1, input int y1,
                      input int color, input bit clr, input bit snc, input bit vs);
    int n;
    bus.cmd_x0    = 9'(x0);
    bus.cmd_y0    = 9'(y0);
    bus.cmd_x1    = 9'(x1);
    bus.cmd_y1    = 9'(y1);
    bus.cmd_color = 12'(color);
    bus.cmd_clear = clr;
    bus.cmd_sync  = snc;
    bus.cmd_valid = 1'b1;
    vsync_pulse   = vs;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.cmd_ready) chk("accept_timeout", 0, 1);
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_clear = 1'b0;
    bus.cmd_sync  = 1'b0;
    vsync_pulse   = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int exp_i[6];
    int exp_j[6];
    exp_i = '{5, 5, 5, 6, 6, 6};
    exp_j = '{10, 11, 12, 10, 11, 12};
    bus.cmd_valid = 1'b0;
    bus.cmd_x0    = '0;
    bus.cmd_y0    = '0;
    bus.cmd_x1    = '0;
    bus.cmd_y1    = '0;
    bus.cmd_color = '0;
    bus.cmd_clear = 1'b0;
    bus.cmd_sync  = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_ready", int'(bus.cmd_ready), 0);
    chk("rst_rw", int'(bus.rw), 0);
    chk("rst_i", int'(bus.i), 0);
    chk("rst_j", int'(bus.j), 0);
    chk("rst_wval", int'(bus.wval), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", int'(bus.cmd_ready), 1);

    // Small rectangle, latency 1
    clear_capture();
    send(10, 5, 12, 6, 'hF00, 1'b0, 1'b0, 1'b0);
    chk("t1_latency_rw", int'(bus.rw), 1);
    wait_done(50);
    chk("t1_writes", wr_count, 6);
    for (int k = 0; k < 6; k++) begin
      chk("t1_row", (k < qi.size()) ? qi[k] : -1, exp_i[k]);
      chk("t1_col", (k < qj.size()) ? qj[k] : -1, exp_j[k]);
    end
    chk("t1_wval", first_wval, 'hF00);
    chk("t1_dones", done_count, 1);
    tick();
    chk("t1_ready_after_done", int'(bus.cmd_ready), 1);
    $display("txn1 rect (5,10)-(6,12) writes=%0d", wr_count);

    // Clamp and swap
    clear_capture();
    send(400, 300, 318, 238, 'h0AB, 1'b0, 1'b0, 1'b0);
    wait_done(50);
    chk("t2_writes", wr_count, 4);
    chk("t2_first_row", first_i, 238);
    chk("t2_first_col", first_j, 318);
    chk("t2_last_addr", last_j + last_i * 320, 76799);
    tick();
    $display("txn2 clamp writes=%0d last=(%0d,%0d)", wr_count, last_i, last_j);

    // Full clear; coordinates must be ignored
    clear_capture();
    send(5, 5, 6, 6, 'h000, 1'b1, 1'b0, 1'b0);
    wait_done(80000);
    chk("t3_writes", wr_count, 76800);
    chk("t3_first_row", first_i, 0);
    chk("t3_first_col", first_j, 0);
    chk("t3_last_row", last_i, 239);
    chk("t3_last_col", last_j, 319);
    tick();
    chk("t3_dones", done_count, 1);
    $display("txn3 clear writes=%0d dones=%0d", wr_count, done_count);

    // Deferred start: pulse on accept edge ignored, next pulse 50 cycles on
    clear_capture();
    send(0, 0, 1, 0, 'h123, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 49; k++) begin
      if (k == 0 || k == 48) begin
        chk("t4_rw_waiting", int'(bus.rw), 0);
        chk("t4_busy_waiting", int'(busy), 1);
      end
      tick();
    end
    chk("t4_no_writes_before_vsync", wr_count, 0);
    vsync_pulse = 1'b1;
    tick();
    vsync_pulse = 1'b0;
    chk("t4_first_write", int'(bus.rw), 1);
    wait_done(20);
    chk("t4_writes", wr_count, 2);
    tick();
    $display("txn4 vsync writes=%0d", wr_count);

    // Abort during clear at write #100
    clear_capture();
    send(0, 0, 0, 0, 'h555, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (wr_count < 100 && n < 500) begin
      tick();
      n++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_done_next", int'(done), 1);
    chk("t5_writes", wr_count, 100);
    tick();
    chk("t5_ready", int'(bus.cmd_ready), 1);
    chk("t5_dones", done_count, 1);
    $display("txn5 abort writes=%0d dones=%0d", wr_count, done_count);

    // Reset mid-fill at write #20
    clear_capture();
    send(0, 0, 0, 0, 'h0F0, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (wr_count < 20 && n < 500) begin
      tick();
      n++;
    end
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rw_async", int'(bus.rw), 0);
    chk("t6_busy_async", int'(busy), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("t6_ready_after_rst", int'(bus.cmd_ready), 1);
    chk("t6_writes", wr_count, 20);
    chk("t6_no_done", done_count, 0);
    $display("txn6 reset writes=%0d dones=%0d", wr_count, done_count);

    clear_capture();
    send(0, 0, 0, 0, 'hABC, 1'b0, 1'b0, 1'b0);
    wait_done(20);
    chk("t7_writes", wr_count, 1);
    chk("t7_row", first_i, 0);
    chk("t7_col", first_j, 0);
    tick();
    $display("txn7 single writes=%0d", wr_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rect_fill_engine.md
Name: rect_fill_engine

Overview:
- Upstream write-side stage of the frame buffer: takes fill commands over a valid/ready handshake and emits one pixel write per clock on the frame buffer write port (i, j, wval, rw).
- Supports rectangle fill, full-frame clear and start deferred to vertical sync (tear-free updates).
- Frame buffer is 320x240, 12-bit RGB (4:4:4); i = row, j = column; buffer write address is j + i*320.

Parameters:
- FB_W, 320, frame width in pixels
- FB_H, 240, frame height in pixels
- COLOR_W, 12, pixel colour width

Ports:
- clk  in  1  system clock; all state changes on posedge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_x0  in  9  start column
- cmd_y0  in  9  start row
- cmd_x1  in  9  end column (inclusive)
- cmd_y1  in  9  end row (inclusive)
- cmd_color  in  COLOR_W  fill colour
- cmd_clear  in  1  ignore coords; fill whole frame
- cmd_sync  in  1  defer start to next vsync_pulse
- vsync_pulse  in  1  one-cycle frame-start strobe from timing generator
- abort  in  1  terminate current command
- i  out  9  write row to frame buffer
- j  out  9  write column to frame buffer
- wval  out  COLOR_W  write data
- rw  out  1  write enable; one pixel written per high cycle
- busy  out  1  high in WAIT_SYNC or FILL
- done  out  1  one-cycle completion strobe

Behaviour:
- Reset (async, immediate): state IDLE; i=0, j=0, wval=0, rw=0, busy=0, done=0, cmd_ready=0. cmd_ready rises on the first posedge after rst deasserts.
- All outputs registered; stable for a full cycle so the downstream negedge write samples clean values.
- States: IDLE, WAIT_SYNC, FILL, DONE.
- IDLE:
  - cmd_ready=1.
  - Accept on posedge with cmd_valid & cmd_ready; latch the normalised command and drop cmd_ready.
  - Next state is WAIT_SYNC if cmd_sync, otherwise FILL.
- Normalisation at accept:
  - cmd_clear=1 forces x0=0, y0=0, x1=FB_W-1, y1=FB_H-1.
  - Otherwise clamp each x to FB_W-1 and each y to FB_H-1.
  - If x0>x1, swap them; if y0>y1, swap them.
- WAIT_SYNC:
  - busy=1, rw=0.
  - First vsync_pulse sampled at a posedge after the accept edge moves to FILL. A pulse on the accept edge itself is ignored.
- FILL:
  - rw=1, wval=colour, busy=1.
  - Raster order: j steps x0..x1; at j==x1, j returns to x0 and i increments.
  - First write cycle has i=y0, j=x0. With no sync, rw is high in the cycle immediately after the accept edge (latency 1).
  - Exactly (x1-x0+1)*(y1-y0+1) consecutive rw-high cycles, no gaps. A full clear is 76800 cycles.
  - After the write at (y1,x1), go to DONE.
- DONE:
  - done=1 and rw=0 for one cycle, then IDLE.
  - cmd_ready=1 in the cycle after done; back-to-back commands therefore have a 2-cycle gap between last and first write.
- abort:
  - Sampled in WAIT_SYNC or FILL; ignored in IDLE and DONE.
  - At that edge: rw=0, go to DONE, done pulses. Writes already issued remain.
  - abort and last-pixel on the same edge yields a single done.
- cmd inputs are ignored while cmd_ready=0; holding cmd_valid does not queue a command.
- Reset mid-FILL: rw drops immediately, command discarded, no done.
- Counter widths: i and j are 9 bits; no wrap is reachable after clamping.

Test Plan:
- Reset, then cmd x0=10,y0=5,x1=12,y1=6,color=0xF00,sync=0 -> rw high 6 consecutive cycles starting 1 cycle after accept; (i,j) = (5,10),(5,11),(5,12),(6,10),(6,11),(6,12); wval=0xF00; done one cycle later.
- cmd x0=400,y0=300,x1=318,y1=238 -> clamps/swaps to cols 318..319, rows 238..239; 4 writes, last at (239,319) (address 76799).
- cmd_clear=1,color=0x000 -> 76800 writes, first (0,0), last (239,319); busy high throughout; done exactly once.
- cmd_sync=1 with vsync_pulse on the accept edge, next pulse 50 cycles later -> rw stays 0 for the 50 cycles; first write on the cycle after the second pulse.
- Clear running, abort at write #100 -> exactly 100 writes, done next cycle, cmd_ready=1 the cycle after.
- rst asserted mid-fill at write #20 -> rw=0 immediately (between edges), no done; after release, cmd_ready=1 on first posedge and a new 1x1 command at (0,0) writes once.
